// File: rtl/ring_rr_arbiter_pkg.sv
// ring_rr_arbiter_pkg: shared state type and one-hot helpers for the ring arbiter
package ring_rr_arbiter_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int onehot_to_idx(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (v[i]) r = i;
    return r;
  endfunction
  // rotate left within the low n bits; top bit wraps to bit 0
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return ((v << 1) | (v >> (n - 1))) & ~(32'hffff_ffff << n);
  endfunction
endpackage

// File: rtl/ring_rr_arbiter_if.sv
// ring_rr_arbiter_if: request/grant bundle between requesters and the arbiter
interface ring_rr_arbiter_if #(parameter int N = 4, parameter int IDW = 2);
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic busy;
  logic preempt;
  modport master(output req, input gnt, gnt_id, busy, preempt);
  modport slave(input req, output gnt, gnt_id, busy, preempt);
endinterface

// File: rtl/ring_rr_arbiter_pick.sv
// ring_prio_pick: first set request bit found circularly from the one-hot ptr position
module ring_prio_pick #(parameter int N = 4) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);
  logic [2*N-1:0] dr, g;
  assign dr = {req, req};
  // lowest set bit at or above ptr in the doubled vector; upper half covers the wrap
  assign g = dr & ~(dr - {{N{1'b0}}, ptr});
  assign win = g[N-1:0] | g[2*N-1:N];
endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter: round-robin arbiter with rotating one-hot priority and hold-timeout preemption
module ring_rr_arbiter
  import ring_rr_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  parameter int IDW = 2
) (
  input logic clk,
  input logic rst_n,
  ring_rr_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD);
  state_t state, state_n;
  logic [N-1:0] ptr, ptr_n, gnt, gnt_n, win;
  logic [HW-1:0] hold, hold_n;
  logic pre, pre_n, tmo, keep;
  ring_prio_pick #(.N(N)) u_pick (.req(bus.req), .ptr(ptr), .win(win));
  assign tmo = hold == HW'(MAX_HOLD - 1);
  assign keep = |(bus.req & gnt);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= N'(1);
      gnt <= '0;
      hold <= '0;
      pre <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      gnt <= gnt_n;
      hold <= hold_n;
      pre <= pre_n;
    end
  end
  // a release wins over a simultaneous timeout, so preempt only fires while the owner still requests
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gnt_n = gnt;
    hold_n = hold;
    pre_n = 1'b0;
    if (state == IDLE) begin
      gnt_n = |bus.req ? win : '0;
      state_n = |bus.req ? BUSY : IDLE;
      hold_n = '0;
    end else if (!keep || (tmo && |(bus.req & ~gnt))) begin
      gnt_n = '0;
      ptr_n = N'(rotl(32'(gnt), N));
      state_n = IDLE;
      pre_n = keep;
    end else hold_n = tmo ? '0 : hold + 1'b1;
  end
  assign bus.gnt = gnt;
  assign bus.gnt_id = IDW'(onehot_to_idx(32'(gnt)));
  assign bus.busy = |gnt;
  assign bus.preempt = pre;
endmodule
